phys_free_list: RTL and testbench

- Circular FIFO of free physical register indices.
- Rename/dispatch draws up to two destination physical registers per cycle from it.
- The retire stage returns up to two old physical registers per cycle over the rt_flag_1/fp_i_1 and rt_flag_2/fp_i_2 release interface.
- A presence bitmap rejects double frees and frees of the hard-wired zero register.

---
 rtl/phys_free_list.sv | 92 +++++++++
 tb/tb_phys_free_list.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices with double-free protection.
// Grant and alloc_p_* are combinational from registered state; free_count lags one edge.
// No backpressure: the requester stalls and retries on alloc_gnt=0; release is always accepted or dropped.
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32,
  parameter int PW        = $clog2(NUM_PREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    alloc_cnt,
  output logic          alloc_gnt,
  output logic [PW-1:0] alloc_p_1,
  output logic [PW-1:0] alloc_p_2,
  input  logic          rt_flag_1,
  input  logic [PW-1:0] fp_i_1,
  input  logic          rt_flag_2,
  input  logic [PW-1:0] fp_i_2,
  output logic [PW:0]   free_count,
  output logic          err_double_free,
  output logic          err_illegal_req
);

  // Pointers wrap by natural PW-bit overflow, so NUM_PREGS must be a power of two.
  localparam int NUM_FREE0 = NUM_PREGS - NUM_ARCH;

  logic [PW-1:0]        mem [NUM_PREGS];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [PW:0]          count;
  logic [NUM_PREGS-1:0] in_list;

  logic [PW-1:0]        head_p1;
  logic [PW-1:0]        tail_p1;
  logic [PW-1:0]        wr_addr_2;
  logic [1:0]           n_pop;
  logic [1:0]           n_push;
  logic                 push_1;
  logic                 push_2;

  // Grant from the pre-edge count only, and release validity against the pre-edge bitmap.
  always_comb begin
    head_p1   = head + PW'(1);
    tail_p1   = tail + PW'(1);
    alloc_p_1 = mem[head];
    alloc_p_2 = mem[head_p1];
    alloc_gnt = ((alloc_cnt == 2'd1) && (count >= (PW+1)'(1))) ||
                ((alloc_cnt == 2'd2) && (count >= (PW+1)'(2)));
    n_pop     = alloc_gnt ? alloc_cnt : 2'd0;
    push_1    = rt_flag_1 && (fp_i_1 != '0) && !in_list[fp_i_1];
    // Slot 2 loses a same-register tie with an accepted slot 1.
    push_2    = rt_flag_2 && (fp_i_2 != '0) && !in_list[fp_i_2] &&
                !(push_1 && (fp_i_1 == fp_i_2));
    n_push    = {1'b0, push_1} + {1'b0, push_2};
    wr_addr_2 = push_1 ? tail_p1 : tail;
  end

  // Pointer, storage, bitmap and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem[i]     <= (i < NUM_FREE0) ? PW'(NUM_ARCH + i) : '0;
        in_list[i] <= (i >= NUM_ARCH);
      end
      head            <= '0;
      tail            <= PW'(NUM_FREE0);
      count           <= (PW+1)'(NUM_FREE0);
      err_double_free <= 1'b0;
      err_illegal_req <= 1'b0;
    end else begin
      if (push_1) mem[tail]      <= fp_i_1;
      if (push_2) mem[wr_addr_2] <= fp_i_2;
      // Popped registers are still listed pre-edge, so they never collide with a push below.
      if (n_pop != 2'd0) in_list[alloc_p_1] <= 1'b0;
      if (n_pop == 2'd2) in_list[alloc_p_2] <= 1'b0;
      if (push_1) in_list[fp_i_1] <= 1'b1;
      if (push_2) in_list[fp_i_2] <= 1'b1;
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(n_push);
      count <= count - (PW+1)'(n_pop) + (PW+1)'(n_push);
      if ((rt_flag_1 && !push_1) || (rt_flag_2 && !push_2)) err_double_free <= 1'b1;
      if (alloc_cnt == 2'd3) err_illegal_req <= 1'b1;
    end
  end

  assign free_count = count;

  // p0 is never listed, so the list can never hold every register.
  count_bound_a: assert property (@(posedge clk) disable iff (rst)
    count <= (PW+1)'(NUM_PREGS - 1));

endmodule

// File: tb/tb_phys_free_list.sv
// Testbench for phys_free_list: directed vector table, hand corner sequences, steered random traffic.
// Combinational outputs checked mid-cycle; registered outputs checked via a scoreboard queue after each edge.
// No backpressure on the bench side; every cycle is a fixed number of clocks.
module tb_phys_free_list;
  localparam int NP = 64;
  localparam int NA = 32;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    alloc_cnt;
  logic          alloc_gnt;
  logic [PW-1:0] alloc_p_1;
  logic [PW-1:0] alloc_p_2;
  logic          rt_flag_1;
  logic [PW-1:0] fp_i_1;
  logic          rt_flag_2;
  logic [PW-1:0] fp_i_2;
  logic [PW:0]   free_count;
  logic          err_double_free;
  logic          err_illegal_req;

  always #5 clk = ~clk;

  phys_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (
    .clk(clk), .rst(rst), .alloc_cnt(alloc_cnt), .alloc_gnt(alloc_gnt),
    .alloc_p_1(alloc_p_1), .alloc_p_2(alloc_p_2),
    .rt_flag_1(rt_flag_1), .fp_i_1(fp_i_1), .rt_flag_2(rt_flag_2), .fp_i_2(fp_i_2),
    .free_count(free_count), .err_double_free(err_double_free), .err_illegal_req(err_illegal_req)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered free list plus membership bitmap and pointer positions.
  int fl[$];
  bit inl[NP];
  bit m_edf, m_eil;
  int m_head, m_tail;
  int pop_straddle, push_straddle;

  typedef struct { int fc; bit edf; bit eil; } exp_t;
  exp_t sb[$];

  typedef struct {
    int cnt; int r1; int f1; int r2; int f2;
    int gnt; int p1; int p2; int fc;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    for (int i = 0; i < NP; i++) inl[i] = (i >= NA);
    for (int i = 0; i < NP - NA; i++) fl.push_back(NA + i);
    m_edf = 0; m_eil = 0;
    m_head = 0; m_tail = NP - NA;
  endtask

  // One clock: drive at negedge, check combinational outputs, model the edge, check registered outputs.
  task automatic step(input int cnt, input int r1, input int f1, input int r2, input int f2,
                      output int og, output int op1, output int op2, output int ofc);
    int sz;
    bit eg, v1, v2;
    int npop, npush;
    exp_t e;
    alloc_cnt = 2'(cnt);
    rt_flag_1 = r1[0]; fp_i_1 = PW'(f1);
    rt_flag_2 = r2[0]; fp_i_2 = PW'(f2);
    #1;
    og = int'(alloc_gnt); op1 = int'(alloc_p_1); op2 = int'(alloc_p_2);
    sz = fl.size();
    eg = (cnt == 1 && sz >= 1) || (cnt == 2 && sz >= 2);
    check("alloc_gnt", og, int'(eg));
    if (sz >= 1) check("alloc_p_1", op1, fl[0]);
    if (sz >= 2) check("alloc_p_2", op2, fl[1]);
    v1 = (r1 != 0) && (f1 != 0) && !inl[f1];
    v2 = (r2 != 0) && (f2 != 0) && !inl[f2] && !(v1 && f1 == f2);
    if (((r1 != 0) && !v1) || ((r2 != 0) && !v2)) m_edf = 1;
    if (cnt == 3) m_eil = 1;
    npop = eg ? cnt : 0;
    if (npop == 2 && m_head == NP - 1) pop_straddle++;
    for (int k = 0; k < npop; k++) begin
      inl[fl[0]] = 0;
      void'(fl.pop_front());
    end
    m_head = (m_head + npop) % NP;
    npush = int'(v1) + int'(v2);
    if (npush == 2 && m_tail == NP - 1) push_straddle++;
    if (v1) begin fl.push_back(f1); inl[f1] = 1; end
    if (v2) begin fl.push_back(f2); inl[f2] = 1; end
    m_tail = (m_tail + npush) % NP;
    sb.push_back('{fc: fl.size(), edf: m_edf, eil: m_eil});
    @(posedge clk);
    #1;
    ofc = int'(free_count);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("free_count", ofc, e.fc);
      check("err_double_free", int'(err_double_free), int'(e.edf));
      check("err_illegal_req", int'(err_illegal_req), int'(e.eil));
    end
    @(negedge clk);
  endtask

  // Find an allocated (not free, nonzero) register other than excl; 0 if none.
  function automatic int pick_alloc(input int excl);
    int start;
    start = $urandom_range(1, NP - 1);
    for (int k = 0; k < NP - 1; k++) begin
      int r;
      r = 1 + ((start - 1 + k) % (NP - 1));
      if (!inl[r] && r != excl) return r;
    end
    return 0;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_free_count"}, int'(free_count), 32);
    check({tag, "_alloc_p_1"}, int'(alloc_p_1), 32);
    check({tag, "_alloc_p_2"}, int'(alloc_p_2), 33);
    check({tag, "_err_double_free"}, int'(err_double_free), 0);
    check({tag, "_err_illegal_req"}, int'(err_illegal_req), 0);
    check({tag, "_alloc_gnt_idle"}, int'(alloc_gnt), 0);
  endtask

  initial begin
    vec_t vt[5];
    int g, p1, p2, fc;
    int cnt, r1, f1, r2, f2;

    rst = 1'b1; alloc_cnt = 2'd0;
    rt_flag_1 = 1'b0; fp_i_1 = '0; rt_flag_2 = 1'b0; fp_i_2 = '0;
    pop_straddle = 0; push_straddle = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset");
    @(negedge clk);

    // Directed vectors from reset: cnt, r1, f1, r2, f2, gnt, p1, p2, free_count after edge.
    vt[0] = '{2, 0, 0, 0, 0, 1, 32, 33, 30};
    vt[1] = '{2, 0, 0, 0, 0, 1, 34, 35, 28};
    vt[2] = '{1, 0, 0, 0, 0, 1, 36, 37, 27};
    vt[3] = '{0, 0, 0, 0, 0, 0, 37, 38, 27};
    vt[4] = '{1, 1, 3, 0, 0, 1, 37, 38, 27};
    for (int i = 0; i < 5; i++) begin
      step(vt[i].cnt, vt[i].r1, vt[i].f1, vt[i].r2, vt[i].f2, g, p1, p2, fc);
      check($sformatf("vec%0d_gnt", i), g, vt[i].gnt);
      check($sformatf("vec%0d_p1", i), p1, vt[i].p1);
      check($sformatf("vec%0d_p2", i), p2, vt[i].p2);
      check($sformatf("vec%0d_fc", i), fc, vt[i].fc);
    end

    // Drain pairs: 27 free -> 1 left, which is p3 released above.
    for (int i = 0; i < 13; i++) step(2, 0, 0, 0, 0, g, p1, p2, fc);
    check("drain_fc", fc, 1);
    step(2, 0, 0, 0, 0, g, p1, p2, fc);
    check("short_pair_gnt", g, 0);
    check("short_pair_fc", fc, 1);
    check("short_pair_p1", p1, 3);
    step(1, 0, 0, 0, 0, g, p1, p2, fc);
    check("last_one_gnt", g, 1);
    check("last_one_fc", fc, 0);
    step(1, 0, 0, 0, 0, g, p1, p2, fc);
    check("empty_gnt", g, 0);
    check("empty_fc", fc, 0);

    // Release into an empty list while requesting: grant uses the pre-edge count.
    step(1, 1, 5, 1, 7, g, p1, p2, fc);
    check("rel_empty_gnt", g, 0);
    check("rel_empty_fc", fc, 2);
    step(0, 0, 0, 0, 0, g, p1, p2, fc);
    check("rel_order_p1", p1, 5);
    check("rel_order_p2", p2, 7);

    // Illegal releases and requests.
    step(0, 1, 9, 0, 0, g, p1, p2, fc);
    check("free9_fc", fc, 3);
    check("free9_edf", int'(err_double_free), 0);
    step(0, 1, 9, 0, 0, g, p1, p2, fc);
    check("dbl9_fc", fc, 3);
    check("dbl9_edf", int'(err_double_free), 1);
    step(0, 0, 0, 1, 0, g, p1, p2, fc);
    check("free_p0_fc", fc, 3);
    step(3, 0, 0, 0, 0, g, p1, p2, fc);
    check("cnt3_gnt", g, 0);
    check("cnt3_fc", fc, 3);
    check("cnt3_eil", int'(err_illegal_req), 1);
    step(0, 1, 11, 1, 11, g, p1, p2, fc);
    check("same_reg_fc", fc, 4);
    step(1, 1, 5, 0, 0, g, p1, p2, fc);
    check("pop_rerelease_fc", fc, 3);
    step(0, 0, 0, 1, 12, g, p1, p2, fc);
    check("slot2_only_fc", fc, 4);
    check("sticky_edf", int'(err_double_free), 1);
    check("sticky_eil", int'(err_illegal_req), 1);

    // Steered random traffic; forces two-entry pops and pushes across index 63 -> 0.
    for (int c = 0; c < 600; c++) begin
      cnt = $urandom_range(0, 2);
      if (m_head == NP - 1 && fl.size() >= 2) cnt = 2;
      r1 = 0; f1 = 0; r2 = 0; f2 = 0;
      if (m_tail == NP - 1 || $urandom_range(0, 1) == 1) begin
        f1 = pick_alloc(0); r1 = 1;
      end
      if (m_tail == NP - 1 || $urandom_range(0, 1) == 1) begin
        f2 = pick_alloc(f1); r2 = 1;
      end
      if ($urandom_range(0, 15) == 0) f2 = $urandom_range(0, NP - 1);
      step(cnt, r1, f1, r2, f2, g, p1, p2, fc);
    end
    check("pop_straddle_seen", int'(pop_straddle > 0), 1);
    check("push_straddle_seen", int'(push_straddle > 0), 1);

    // Reset in the middle of traffic overrides everything driven that cycle.
    rst = 1'b1; alloc_cnt = 2'd2;
    rt_flag_1 = 1'b1; fp_i_1 = PW'(pick_alloc(0));
    rt_flag_2 = 1'b1; fp_i_2 = PW'(9);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; alloc_cnt = 2'd0;
    rt_flag_1 = 1'b0; fp_i_1 = '0; rt_flag_2 = 1'b0; fp_i_2 = '0;
    model_reset();
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    step(2, 0, 0, 0, 0, g, p1, p2, fc);
    check("midrst_alloc_p1", p1, 32);
    check("midrst_alloc_fc", fc, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
